// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU arbiter: op-word layout,
//               function-class codes, logic/shift sub-function codes and the
//               arbiter FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package alu_pkg;

    // Op word layout: {fn_class[8:6], add_sub[5], const_var[4],
    //                  logic_fn[3:2], shift_fn[1:0]}
    localparam int c_OP_W          = 9;
    localparam int c_OP_FN_MSB     = 8;
    localparam int c_OP_FN_LSB     = 6;
    localparam int c_OP_ADDSUB_BIT = 5;
    localparam int c_OP_CONST_BIT  = 4;
    localparam int c_OP_LOGIC_MSB  = 3;
    localparam int c_OP_LOGIC_LSB  = 2;
    localparam int c_OP_SHIFT_MSB  = 1;
    localparam int c_OP_SHIFT_LSB  = 0;

    // Function classes
    localparam logic [2:0] c_FN_LUI     = 3'b000;
    localparam logic [2:0] c_FN_SLT     = 3'b001;
    localparam logic [2:0] c_FN_SGT     = 3'b010;
    localparam logic [2:0] c_FN_ADDSUB  = 3'b011;
    localparam logic [2:0] c_FN_LOGIC   = 3'b100;
    localparam logic [2:0] c_FN_SHIFT   = 3'b101;
    localparam logic [2:0] c_FN_HAM     = 3'b110;
    localparam logic [2:0] c_FN_ILLEGAL = 3'b111;

    // Logic sub-functions
    localparam logic [1:0] c_LOGIC_AND = 2'b00;
    localparam logic [1:0] c_LOGIC_OR  = 2'b01;
    localparam logic [1:0] c_LOGIC_XOR = 2'b10;
    localparam logic [1:0] c_LOGIC_NOR = 2'b11;

    // Shift sub-functions
    localparam logic [1:0] c_SHIFT_SLL = 2'b00;
    localparam logic [1:0] c_SHIFT_SRL = 2'b01;
    localparam logic [1:0] c_SHIFT_SRA = 2'b10;
    localparam logic [1:0] c_SHIFT_ROL = 2'b11;

    // Packed view of the op word; field order matches the bit positions above.
    typedef struct packed {
        logic [2:0] fn_class;
        logic       add_sub;
        logic       const_var;
        logic [1:0] logic_fn;
        logic [1:0] shift_fn;
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
//==============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone requester always wins; on
//               a tie the requester that was not granted last wins.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_req[1:0]    - request vector
//               i_advance     - the current grant was taken; update history
//               o_grant[1:0]  - one-hot grant (combinational from i_req)
// Revision    : 1.0 - initial release
//==============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Reset value 1 so requester 0 wins the first tie.
    logic       r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance && (w_grant != 2'b00)) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between the execute stage (req 0)
//               and the address/branch unit (req 1). Round-robin grant,
//               registered ALU operands, captured result returned on a
//               per-requester response channel with backpressure.
// Ports       : clk, rst                  - clock, sync active-high reset
//               reqN_valid/ready/x/y/op   - request channels (N = 0, 1)
//               rspN_valid/ready/result/overflow/err - response channels
//               alu_* (out)               - registered ALU operands/controls
//               alu_result, alu_overflow  - combinational ALU outputs
// Revision    : 1.0 - initial release
//==============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic [c_OP_W-1:0] req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    input  logic [c_OP_W-1:0] req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_overflow,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_overflow,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_fn_class,
    output logic              alu_add_sub,
    output logic              alu_const_var,
    output logic [1:0]        alu_logic_fn,
    output logic [1:0]        alu_shift_fn,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow
);

    state_t            r_state;
    logic              r_grant_idx;     // requester owning the in-flight op
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    op_t               r_op;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_overflow;
    logic              r_rsp_err;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    op_t               w_op;
    logic              w_rsp_ready;

    // Requests are only offered to the arbiter in IDLE, so the grant doubles
    // as the ready vector and implies the matching valid.
    assign w_req    = {req1_valid, req0_valid} & {2{r_state == ST_IDLE}};
    assign w_accept = |w_grant;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_x  = w_grant[1] ? req1_x : req0_x;
    assign w_y  = w_grant[1] ? req1_y : req0_y;
    assign w_op = w_grant[1] ? op_t'(req1_op) : op_t'(req0_op);

    assign w_rsp_ready = r_grant_idx ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant_idx    <= 1'b0;
            r_alu_x        <= '0;
            r_alu_y        <= '0;
            r_op           <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant_idx <= w_grant[1];
                        r_alu_x     <= w_x;
                        r_alu_y     <= w_y;
                        r_op        <= w_op;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The ALU flag only means something for add/sub; an
                    // illegal class is sequenced but reports only err.
                    r_rsp_valid    <= 1'b1;
                    r_rsp_err      <= (r_op.fn_class == c_FN_ILLEGAL);
                    r_rsp_result   <= (r_op.fn_class == c_FN_ILLEGAL) ? '0 : alu_result;
                    r_rsp_overflow <= (r_op.fn_class == c_FN_ADDSUB) ? alu_overflow : 1'b0;
                    r_alu_x        <= '0;
                    r_alu_y        <= '0;
                    r_op           <= '0;
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ready) begin
                        r_rsp_valid    <= 1'b0;
                        r_rsp_result   <= '0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_err      <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers are zero outside RESP, so steering by grant index is
    // enough to keep the non-granted channel at 0.
    assign rsp0_valid    = r_rsp_valid & ~r_grant_idx;
    assign rsp1_valid    = r_rsp_valid &  r_grant_idx;
    assign rsp0_result   = r_grant_idx ? '0 : r_rsp_result;
    assign rsp1_result   = r_grant_idx ? r_rsp_result : '0;
    assign rsp0_overflow = r_rsp_overflow & ~r_grant_idx;
    assign rsp1_overflow = r_rsp_overflow &  r_grant_idx;
    assign rsp0_err      = r_rsp_err & ~r_grant_idx;
    assign rsp1_err      = r_rsp_err &  r_grant_idx;

    assign alu_x         = r_alu_x;
    assign alu_y         = r_alu_y;
    assign alu_fn_class  = r_op.fn_class;
    assign alu_add_sub   = r_op.add_sub;
    assign alu_const_var = r_op.const_var;
    assign alu_logic_fn  = r_op.logic_fn;
    assign alu_shift_fn  = r_op.shift_fn;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A behavioural ALU answers
//               the alu_* outputs (raising its overflow flag for every
//               non-add/sub class so masking is exercised). Stimulus pushes
//               hand-computed responses into per-requester queues; a negedge
//               monitor pops and compares on every response handshake.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
    logic [8:0]    req0_op, req1_op;
    logic          rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_err;
    logic          rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_err;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic [W-1:0]  alu_x, alu_y, alu_result;
    logic [2:0]    alu_fn_class;
    logic          alu_add_sub, alu_const_var, alu_overflow;
    logic [1:0]    alu_logic_fn, alu_shift_fn;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_err(rsp1_err),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fn_class(alu_fn_class), .alu_add_sub(alu_add_sub),
        .alu_const_var(alu_const_var), .alu_logic_fn(alu_logic_fn), .alu_shift_fn(alu_shift_fn),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );

    // Behavioural ALU
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b1;
        case (alu_fn_class)
            c_FN_LUI: alu_result = {alu_y[15:0], 16'h0000};
            c_FN_SLT: alu_result = {{(W-1){1'b0}}, $signed(alu_x) < $signed(alu_y)};
            c_FN_SGT: alu_result = {{(W-1){1'b0}}, $signed(alu_x) > $signed(alu_y)};
            c_FN_ADDSUB: begin
                alu_result = alu_add_sub ? (alu_x - alu_y) : (alu_x + alu_y);
                if (alu_add_sub)
                    alu_overflow = (alu_x[W-1] != alu_y[W-1]) && (alu_result[W-1] != alu_x[W-1]);
                else
                    alu_overflow = (alu_x[W-1] == alu_y[W-1]) && (alu_result[W-1] != alu_x[W-1]);
            end
            c_FN_LOGIC: begin
                case (alu_logic_fn)
                    c_LOGIC_AND: alu_result = alu_x & alu_y;
                    c_LOGIC_OR:  alu_result = alu_x | alu_y;
                    c_LOGIC_XOR: alu_result = alu_x ^ alu_y;
                    default:     alu_result = ~(alu_x | alu_y);
                endcase
            end
            c_FN_SHIFT: begin
                case (alu_shift_fn)
                    c_SHIFT_SLL: alu_result = alu_x << alu_y[4:0];
                    c_SHIFT_SRL: alu_result = alu_x >> alu_y[4:0];
                    c_SHIFT_SRA: alu_result = $unsigned($signed(alu_x) >>> alu_y[4:0]);
                    default:     alu_result = (alu_x << alu_y[4:0]) | (alu_x >> (6'd32 - {1'b0, alu_y[4:0]}));
                endcase
            end
            c_FN_HAM: alu_result = W'($countones(alu_x ^ alu_y));
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   glog[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input int n, input logic [W-1:0] r, input logic o, input logic e);
        exp_t t;
        t.res = r;
        t.ovf = o;
        t.err = e;
        if (n == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    function automatic logic [8:0] mkop(input logic [2:0] fn, input logic as,
                                        input logic [1:0] lf, input logic [1:0] sf);
        return {fn, as, 1'b0, lf, sf};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic send(input int n, input logic [W-1:0] x, input logic [W-1:0] y, input logic [8:0] op);
        logic got;
        got = 1'b0;
        if (n == 0) begin
            req0_x = x; req0_y = y; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_x = x; req1_y = y; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? req0_ready : req1_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_req%0d: ready never seen within 40 cycles", n);
        end
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic finish_op();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) glog.push_back(0);
            if (req1_valid && req1_ready) glog.push_back(1);
            if ((req0_ready || req1_ready) && (rsp0_valid || rsp1_valid)) begin
                checks++;
                errors++;
                $display("FAIL ready_rsp_overlap: ready and rsp valid together at %0t", $time);
            end
            if (rsp0_valid && rsp0_ready) begin : m0
                exp_t e;
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp0_unexpected: got result 0x%0h, expected no response", rsp0_result);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_result", rsp0_result, e.res);
                    check1("rsp0_overflow", rsp0_overflow, e.ovf);
                    check1("rsp0_err", rsp0_err, e.err);
                end
            end
            if (rsp1_valid && rsp1_ready) begin : m1
                exp_t e;
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp1_unexpected: got result 0x%0h, expected no response", rsp1_result);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_result", rsp1_result, e.res);
                    check1("rsp1_overflow", rsp1_overflow, e.ovf);
                    check1("rsp1_err", rsp1_err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   exp_g[4];
        logic seen;
        exp_g = '{0, 1, 0, 1};
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_op = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_req0_ready", req0_ready, 1'b0);
        check1("reset_rsp0_valid", rsp0_valid, 1'b0);
        check1("reset_rsp1_valid", rsp1_valid, 1'b0);
        check("reset_alu_x", alu_x, '0);
        check("reset_alu_fn_class", W'(alu_fn_class), '0);
        check("reset_rsp1_result", rsp1_result, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single add with signed overflow
        expect_rsp(0, 32'h8000_0000, 1'b1, 1'b0);
        send(0, 32'h7FFF_FFFF, 32'h1, mkop(c_FN_ADDSUB, 1'b0, 2'b00, 2'b00));
        @(negedge clk);
        check("add_t1_alu_x", alu_x, 32'h7FFF_FFFF);
        check("add_t1_alu_y", alu_y, 32'h1);
        check("add_t1_fn_class", W'(alu_fn_class), W'(c_FN_ADDSUB));
        check1("add_t1_rsp0_valid", rsp0_valid, 1'b0);
        @(negedge clk);
        check1("add_t2_rsp0_valid", rsp0_valid, 1'b1);
        @(posedge clk);
        #1;

        // Overflow masked for LOGIC even though the ALU raises its flag
        expect_rsp(1, 32'h0, 1'b0, 1'b0);
        send(1, 32'hAAAA_AAAA, 32'h5555_5555, mkop(c_FN_LOGIC, 1'b0, c_LOGIC_AND, 2'b00));
        finish_op();

        // Illegal class
        expect_rsp(1, 32'h0, 1'b0, 1'b1);
        send(1, 32'h1234_5678, 32'h9, mkop(c_FN_ILLEGAL, 1'b0, 2'b00, 2'b00));
        @(negedge clk);
        check("ill_t1_fn_class", W'(alu_fn_class), W'(c_FN_ILLEGAL));
        @(negedge clk);
        check1("ill_t2_rsp1_valid", rsp1_valid, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check1("ill_back_idle_rsp1_valid", rsp1_valid, 1'b0);
        check("ill_back_idle_fn_class", W'(alu_fn_class), '0);
        @(posedge clk);
        #1;

        // Backpressure on response 0 while req1 waits
        rsp0_ready = 1'b0;
        expect_rsp(0, 32'd7, 1'b0, 1'b0);
        send(0, 32'd10, 32'd3, mkop(c_FN_ADDSUB, 1'b1, 2'b00, 2'b00));
        expect_rsp(1, 32'hF0F0_0F0F, 1'b0, 1'b0);
        req1_x = 32'hF0F0_0000; req1_y = 32'h0000_0F0F;
        req1_op = mkop(c_FN_LOGIC, 1'b0, c_LOGIC_OR, 2'b00);
        req1_valid = 1'b1;
        @(negedge clk);
        check1("bp_exec_req1_ready", req1_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("bp_hold_rsp0_valid", rsp0_valid, 1'b1);
            check("bp_hold_rsp0_result", rsp0_result, 32'd7);
            check1("bp_hold_req1_ready", req1_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        check1("bp_handshake_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        check1("bp_after_req1_ready", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        finish_op();

        // Contention from reset: strict alternation 0,1,0,1
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        glog.delete();
        expect_rsp(0, 32'd11, 1'b0, 1'b0);
        expect_rsp(0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        expect_rsp(1, 32'hF00F_F00F, 1'b0, 1'b0);
        expect_rsp(1, 32'd16, 1'b0, 1'b0);
        fork
            begin
                send(0, 32'd5, 32'd6, mkop(c_FN_ADDSUB, 1'b0, 2'b00, 2'b00));
                send(0, 32'h8000_0000, 32'd1, mkop(c_FN_ADDSUB, 1'b1, 2'b00, 2'b00));
            end
            begin
                send(1, 32'hFF00_FF00, 32'h0F0F_0F0F, mkop(c_FN_LOGIC, 1'b0, c_LOGIC_XOR, 2'b00));
                send(1, 32'd1, 32'd4, mkop(c_FN_SHIFT, 1'b0, 2'b00, c_SHIFT_SLL));
            end
        join
        finish_op();
        check("contention_grant_count", W'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) check("contention_grant_order", W'(glog[i]), W'(exp_g[i]));
        end

        // Reset while in EXEC: response discarded, tie goes back to req0
        send(0, 32'd1, 32'd2, mkop(c_FN_ADDSUB, 1'b0, 2'b00, 2'b00));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_alu_x", alu_x, '0);
        check("rst_mid_fn_class", W'(alu_fn_class), '0);
        check1("rst_mid_rsp0_valid", rsp0_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp0_valid;
        end
        check1("rst_mid_no_response", seen, 1'b0);
        @(posedge clk);
        #1;
        glog.delete();
        expect_rsp(0, 32'd3, 1'b0, 1'b0);
        expect_rsp(1, 32'd16, 1'b0, 1'b0);
        fork
            send(0, 32'd1, 32'd2, mkop(c_FN_ADDSUB, 1'b0, 2'b00, 2'b00));
            send(1, 32'd8, 32'd1, mkop(c_FN_SHIFT, 1'b0, 2'b00, c_SHIFT_SLL));
        join
        finish_op();
        check("rst_tie_grant_count", W'(glog.size()), 32'd2);
        if (glog.size() > 0) check("rst_tie_first_grant", W'(glog[0]), 32'd0);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("q0_drained", W'(q0.size()), 32'd0);
        check("q1_drained", W'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
